sdh_tx_payload_sched: RTL and testbench

- Byte-interleaving scheduler that shares the transmitter payload input between NUM_CH tributary byte sources.
- Answers the transmitter's one-cycle-ahead payload request (sdh_tx_din_req / sdh_tx_din) by serving channels in fixed round-robin slot order.
- Substitutes a fill byte for empty or disabled channels and counts underruns.
- Sits directly upstream of sdh_transmitter; slot order restarts at every payload frame boundary.

---
 rtl/sdh_tx_pkg.sv | 6 +
 rtl/sdh_tx_payload_sched_if.sv | 12 +
 rtl/sdh_sat_cnt.sv | 15 +
 rtl/sdh_tx_payload_sched.sv | 65 ++++++
 tb/tb_sdh_tx_payload_sched.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sdh_tx_pkg.sv
// sdh_tx_pkg: shared scheduler state encoding and STM-1 payload constants
package sdh_tx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} sched_st_e;
  localparam int STM1_PAYLOAD_BYTES = 2349;
  localparam logic [7:0] SDH_FILL_BYTE = 8'h00;
endpackage

// File: rtl/sdh_tx_payload_sched_if.sv
// sdh_tx_payload_sched_if: transmitter payload request and tributary FIFO head signals
interface sdh_tx_payload_sched_if #(parameter int NUM_CH = 4);
  logic                sdh_tx_din_req;
  logic [7:0]          sdh_tx_din;
  logic                frame_start;
  logic [NUM_CH*8-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_valid;
  logic [NUM_CH-1:0]   ch_enable;
  logic [NUM_CH-1:0]   ch_pop;
  modport master (input sdh_tx_din_req, ch_data, ch_valid, ch_enable, output sdh_tx_din, frame_start, ch_pop);
  modport slave (output sdh_tx_din_req, ch_data, ch_valid, ch_enable, input sdh_tx_din, frame_start, ch_pop);
endinterface

// File: rtl/sdh_sat_cnt.sv
// sdh_sat_cnt: saturating up-counter, clear takes priority over increment
module sdh_sat_cnt #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/sdh_tx_payload_sched.sv
// sdh_tx_payload_sched: round-robin byte interleaver feeding the SDH transmitter payload input
module sdh_tx_payload_sched import sdh_tx_pkg::*; #(
  parameter int         NUM_CH        = 4,
  parameter int         PAYLOAD_BYTES = STM1_PAYLOAD_BYTES,
  parameter logic [7:0] FILL_BYTE     = SDH_FILL_BYTE,
  parameter int         CNT_W         = 16
) (
  input  logic                  sdh_clk,
  input  logic                  rst_n,
  sdh_tx_payload_sched_if.master tx,
  input  logic                  sched_en,
  output logic [NUM_CH-1:0]     underrun_pulse,
  output logic [CNT_W-1:0]      underrun_cnt,
  input  logic                  cnt_clr,
  output logic                  sched_busy
);
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(PAYLOAD_BYTES);
  sched_st_e       r_state, w_state_nxt;
  logic [SW-1:0]   r_slot;
  logic [BW-1:0]   r_byte_cnt;
  logic [7:0]      r_din;
  logic            r_fs;
  logic [NUM_CH-1:0] r_ur;
  logic            w_active, w_serve, w_last, w_hit, w_underrun;
  logic [NUM_CH-1:0] w_owner;
  assign w_active   = r_state != ST_IDLE;
  assign w_serve    = tx.sdh_tx_din_req && w_active;
  assign w_last     = r_byte_cnt == BW'(PAYLOAD_BYTES - 1);
  assign w_owner    = NUM_CH'(1) << r_slot;
  assign w_hit      = w_serve && tx.ch_enable[r_slot] && tx.ch_valid[r_slot];
  assign w_underrun = w_serve && tx.ch_enable[r_slot] && !tx.ch_valid[r_slot];
  assign tx.ch_pop      = (rst_n && w_hit) ? w_owner : '0;
  assign tx.sdh_tx_din  = r_din;
  assign tx.frame_start = r_fs;
  assign underrun_pulse = r_ur;
  assign sched_busy     = w_active;
  // RUN and DRAIN schedule alike; DRAIN only differs in falling back to IDLE at frame end
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = sched_en ? ST_RUN : (!w_active || (w_serve && w_last)) ? ST_IDLE : ST_DRAIN;
  end
  always_ff @(posedge sdh_clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_byte_cnt <= '0;
      r_din      <= FILL_BYTE;
      r_fs       <= 1'b0;
      r_ur       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fs    <= w_serve && r_byte_cnt == '0;
      r_ur    <= w_underrun ? w_owner : '0;
      if (tx.sdh_tx_din_req) r_din <= w_hit ? tx.ch_data[r_slot*8 +: 8] : FILL_BYTE;
      // frame length is not a multiple of NUM_CH, so the slot is forced back to 0 each frame
      if (w_serve) begin
        r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
        r_slot     <= (w_last || r_slot == SW'(NUM_CH - 1)) ? '0 : r_slot + 1'b1;
      end
    end
  sdh_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk(sdh_clk), .rst_n(rst_n), .i_inc(w_underrun), .i_clr(cnt_clr), .o_cnt(underrun_cnt)
  );
endmodule

// File: tb/tb_sdh_tx_payload_sched.sv
// tb_sdh_tx_payload_sched: table vectors, frame/drain/reset sequences and a randomized reference-model run
module tb_sdh_tx_payload_sched;
  localparam int NCH = 4, P = 2349;
  logic clk = 1'b0, rst_n = 1'b0, sched_en = 1'b0, cnt_clr = 1'b0;
  logic [NCH-1:0] ur;
  logic [15:0] cnt;
  logic busy;
  logic s_en = 1'b0, s_clr = 1'b0, s_busy;
  logic [1:0] s_ur;
  logic [3:0] s_cnt;
  int nvec = 0, nerr = 0;
  int m_pos, m_cnt;
  bit m_act, m_fs;
  logic [7:0] m_din;
  logic [3:0] m_ur, pop_s;

  sdh_tx_payload_sched_if #(.NUM_CH(NCH)) bus();
  sdh_tx_payload_sched_if #(.NUM_CH(2)) sbus();

  sdh_tx_payload_sched #(.NUM_CH(NCH)) dut (
    .sdh_clk(clk), .rst_n(rst_n), .tx(bus), .sched_en(sched_en), .underrun_pulse(ur),
    .underrun_cnt(cnt), .cnt_clr(cnt_clr), .sched_busy(busy)
  );
  sdh_tx_payload_sched #(.NUM_CH(2), .PAYLOAD_BYTES(5), .CNT_W(4)) u_small (
    .sdh_clk(clk), .rst_n(rst_n), .tx(sbus), .sched_en(s_en), .underrun_pulse(s_ur),
    .underrun_cnt(s_cnt), .cnt_clr(s_clr), .sched_busy(s_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit req; bit sen; logic [3:0] en; logic [3:0] v;
    logic [7:0] din; logic [3:0] pop; bit fs; logic [3:0] ur; logic [15:0] cnt; bit busy;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_act = 1'b0; m_fs = 1'b0; m_din = 8'h00; m_ur = 4'h0;
  endtask

  // Reference: owner is the frame position modulo NUM_CH; scheduling is live while enabled or until the frame ends
  task automatic tick();
    int o;
    logic e, v, req;
    logic [7:0] d;
    logic [3:0] ep;
    bit done;
    o = m_pos % NCH;
    e = bus.ch_enable[o];
    v = bus.ch_valid[o];
    d = bus.ch_data[o*8 +: 8];
    req = bus.sdh_tx_din_req;
    done = 1'b0;
    ep = (m_act && req && e && v) ? 4'(1 << o) : 4'h0;
    #1;
    pop_s = bus.ch_pop;
    chk("pop", {28'h0, pop_s}, {28'h0, ep});
    m_ur = 4'h0;
    m_fs = 1'b0;
    if (req) begin
      m_din = (m_act && e && v) ? d : 8'h00;
      if (m_act) begin
        m_fs = m_pos == 0;
        if (e && !v) begin
          m_ur = 4'(1 << o);
          if (m_cnt < 65535) m_cnt++;
        end
        done = m_pos == P - 1;
        m_pos = (m_pos + 1) % P;
      end
    end
    if (cnt_clr) m_cnt = 0;
    m_act = sched_en || (m_act && !done);
    @(posedge clk);
    #1;
    chk("din", {24'h0, bus.sdh_tx_din}, {24'h0, m_din});
    chk("frame_start", {31'h0, bus.frame_start}, {31'h0, m_fs});
    chk("underrun_pulse", {28'h0, ur}, {28'h0, m_ur});
    chk("underrun_cnt", {16'h0, cnt}, 32'(m_cnt));
    chk("busy", {31'h0, busy}, {31'h0, m_act});
  endtask

  task automatic set_in(input bit req, input bit sen, input logic [3:0] en, input logic [3:0] v);
    bus.sdh_tx_din_req = req; sched_en = sen; bus.ch_enable = en; bus.ch_valid = v;
  endtask

  initial begin
    bus.sdh_tx_din_req = 1'b0; bus.ch_data = 32'hC3C2C1C0; bus.ch_valid = '1; bus.ch_enable = '1;
    sbus.sdh_tx_din_req = 1'b0; sbus.ch_data = '0; sbus.ch_valid = '0; sbus.ch_enable = 2'b11;
    model_reset();
    tbl[0]  = '{1'b1, 1'b0, 4'hF, 4'hF, 8'h00, 4'h0, 1'b0, 4'h0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 4'hF, 8'h00, 4'h0, 1'b0, 4'h0, 16'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 4'hF, 4'hF, 8'hC0, 4'h1, 1'b1, 4'h0, 16'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 4'hF, 4'hF, 8'hC1, 4'h2, 1'b0, 4'h0, 16'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 4'hF, 8'hC1, 4'h0, 1'b0, 4'h0, 16'd0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 4'hF, 4'hF, 8'hC2, 4'h4, 1'b0, 4'h0, 16'd0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 4'hF, 4'hF, 8'hC3, 4'h8, 1'b0, 4'h0, 16'd0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 4'hF, 4'hB, 8'hC0, 4'h1, 1'b0, 4'h0, 16'd0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'hF, 4'hB, 8'hC1, 4'h2, 1'b0, 4'h0, 16'd0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 4'hF, 4'hB, 8'h00, 4'h0, 1'b0, 4'h4, 16'd1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 4'h7, 4'hF, 8'h00, 4'h0, 1'b0, 4'h0, 16'd1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 4'hF, 4'hF, 8'hC0, 4'h1, 1'b0, 4'h0, 16'd1, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_din", {24'h0, bus.sdh_tx_din}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cnt", {16'h0, cnt}, 32'h0);
    set_in(1'b1, 1'b0, 4'hF, 4'hF);
    repeat (4) begin
      tick();
      chk("idle_pop", {28'h0, pop_s}, 32'h0);
      chk("idle_fs", {31'h0, bus.frame_start}, 32'h0);
    end
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].req, tbl[i].sen, tbl[i].en, tbl[i].v);
      tick();
      chk("t_pop", {28'h0, pop_s}, {28'h0, tbl[i].pop});
      chk("t_din", {24'h0, bus.sdh_tx_din}, {24'h0, tbl[i].din});
      chk("t_fs", {31'h0, bus.frame_start}, {31'h0, tbl[i].fs});
      chk("t_ur", {28'h0, ur}, {28'h0, tbl[i].ur});
      chk("t_cnt", {16'h0, cnt}, {16'h0, tbl[i].cnt});
      chk("t_busy", {31'h0, busy}, {31'h0, tbl[i].busy});
    end
    set_in(1'b1, 1'b1, 4'hF, 4'hF);
    while (m_pos != P - 1) tick();
    tick();
    chk("wrap_last_pop", {28'h0, pop_s}, 32'h1);
    chk("wrap_last_din", {24'h0, bus.sdh_tx_din}, 32'hC0);
    tick();
    chk("wrap_first_din", {24'h0, bus.sdh_tx_din}, 32'hC0);
    chk("wrap_first_fs", {31'h0, bus.frame_start}, 32'h1);
    chk("wrap_first_pop", {28'h0, pop_s}, 32'h1);
    while (m_pos != 1000) tick();
    sched_en = 1'b0;
    while (m_pos != P - 1) tick();
    chk("drain_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("drain_idle", {31'h0, busy}, 32'h0);
    tick();
    chk("drain_fill", {24'h0, bus.sdh_tx_din}, 32'h0);
    chk("drain_nopop", {28'h0, pop_s}, 32'h0);
    sched_en = 1'b1;
    while (m_pos != 500) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_din", {24'h0, bus.sdh_tx_din}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_pop", {28'h0, bus.ch_pop}, 32'h0);
    chk("arst_cnt", {16'h0, cnt}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("restart_din", {24'h0, bus.sdh_tx_din}, 32'hC0);
    chk("restart_fs", {31'h0, bus.frame_start}, 32'h1);
    bus.sdh_tx_din_req = 1'b0;
    s_en = 1'b1;
    @(posedge clk);
    #1 sbus.sdh_tx_din_req = 1'b1;
    repeat (14) @(posedge clk);
    #1 chk("sat_fe", {28'h0, s_cnt}, 32'hE);
    chk("sat_busy", {31'h0, s_busy}, 32'h1);
    repeat (3) @(posedge clk);
    #1 chk("sat_hold", {28'h0, s_cnt}, 32'hF);
    chk("sat_pulse", {31'h0, ^s_ur}, 32'h1);
    s_clr = 1'b1;
    @(posedge clk);
    #1 chk("sat_clr", {28'h0, s_cnt}, 32'h0);
    s_clr = 1'b0; sbus.sdh_tx_din_req = 1'b0; s_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bus.sdh_tx_din_req = $urandom_range(0, 3) != 0;
      bus.ch_data = $urandom;
      bus.ch_valid = 4'($urandom);
      bus.ch_enable = 4'($urandom);
      if ($urandom_range(0, 299) == 0) sched_en = !sched_en;
      cnt_clr = $urandom_range(0, 49) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
